index_metric_eval: RTL and testbench

Consumer end of the multi/divi candidate index stream. Holds a per-variable log-likelihood table L[row][col]. For every single-flip or pair-flip candidate beat it computes metric = base + L[mult] - L[divi]; in the log domain the "multi" index adds and the "divi" index subtracts. It tracks the best candidate of a frame and reports it after the last beat. Sits directly downstream of the candidate index generator, with no backpressure.

---
 rtl/index_metric_eval.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_index_metric_eval.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/index_metric_eval.sv
// -----------------------------------------------------------------------------
// index_metric_eval
//
// Purpose:
//   Consumer end of the multi/divi candidate index stream. Holds a per-variable
//   log-likelihood table L[row][col] and, for every single-flip or pair-flip
//   candidate beat, computes metric = base + L[mult] - L[divi]. The best
//   candidate of a frame is tracked and reported after the last beat.
//   Two-stage pipeline (table read, then sum/compare), no backpressure.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_llr_wr_en/_row/_col/_data   table write port (honoured in IDLE/DONE only)
//   i_base_metric                 metric of the initial vector, latched at frame start
//   i_idx_tvalid, i_idx_tlast     index beat valid / last beat of frame
//   i_state_in                    beat kind: 1=frame start, 2=single, 3=pair, 0=ignore
//   i_mult_row/col1/2             added (new) indices
//   i_divi_row/col1/2             subtracted (old) indices
//   o_best_metric                 best metric of the frame
//   o_best_row1/2, o_best_col1/2  rows and new columns of the best candidate
//   o_best_is_pair                best candidate is a pair flip
//   o_cand_cnt                    evaluated candidates, saturating at 0xFFFF
//   o_result_valid                one-cycle pulse when results are final
//   o_busy                        frame start until result_valid
//   o_err_idx                     sticky out-of-range index flag
// -----------------------------------------------------------------------------
module index_metric_eval #(
    parameter  int J       = 14,
    parameter  int A       = 2,
    parameter  int LW      = 12,
    parameter  int MW      = 20,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int AWIDTH  = $clog2(A) + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_llr_wr_en,
    input  logic [J_WIDTH-1:0]        i_llr_wr_row,
    input  logic [AWIDTH-1:0]         i_llr_wr_col,
    input  logic signed [LW-1:0]      i_llr_wr_data,
    input  logic signed [MW-1:0]      i_base_metric,
    input  logic                      i_idx_tvalid,
    input  logic                      i_idx_tlast,
    input  logic [1:0]                i_state_in,
    input  logic [AWIDTH-1:0]         i_mult_col1,
    input  logic [AWIDTH-1:0]         i_mult_col2,
    input  logic [J_WIDTH-1:0]        i_mult_row1,
    input  logic [J_WIDTH-1:0]        i_mult_row2,
    input  logic [AWIDTH-1:0]         i_divi_col1,
    input  logic [AWIDTH-1:0]         i_divi_col2,
    input  logic [J_WIDTH-1:0]        i_divi_row1,
    input  logic [J_WIDTH-1:0]        i_divi_row2,
    output logic signed [MW-1:0]      o_best_metric,
    output logic [J_WIDTH-1:0]        o_best_row1,
    output logic [J_WIDTH-1:0]        o_best_row2,
    output logic [AWIDTH-1:0]         o_best_col1,
    output logic [AWIDTH-1:0]         o_best_col2,
    output logic                      o_best_is_pair,
    output logic [15:0]               o_cand_cnt,
    output logic                      o_result_valid,
    output logic                      o_busy,
    output logic                      o_err_idx
);

    // Table index widths: the extra top bit of the port fields only exists so
    // that out-of-range values can be seen; it is range-checked, not used to index.
    localparam int RIW = (J > 1) ? $clog2(J) : 1;
    localparam int CIW = (A > 1) ? $clog2(A) : 1;
    localparam logic [J_WIDTH-1:0] ROW_LIMIT = J_WIDTH'(J);
    localparam logic [AWIDTH-1:0]  COL_LIMIT = AWIDTH'(A);
    localparam logic signed [MW-1:0] METRIC_MAX = {1'b0, {(MW-1){1'b1}}};
    localparam logic signed [MW-1:0] METRIC_MIN = {1'b1, {(MW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic signed [LW-1:0] r_llr [J][A];

    // Stage 1 registers
    logic                 r_s1_cand;
    logic                 r_s1_pair;
    logic                 r_s1_last;
    logic signed [LW-1:0] r_s1_m1, r_s1_d1, r_s1_m2, r_s1_d2;
    logic [J_WIDTH-1:0]   r_s1_row1, r_s1_row2;
    logic [AWIDTH-1:0]    r_s1_col1, r_s1_col2;

    // Stage 2 / result registers
    logic                 r_s2_last;
    logic signed [MW-1:0] r_base;
    logic signed [MW-1:0] r_best_metric;
    logic [J_WIDTH-1:0]   r_best_row1, r_best_row2;
    logic [AWIDTH-1:0]    r_best_col1, r_best_col2;
    logic                 r_best_is_pair;
    logic [15:0]          r_cand_cnt;
    logic                 r_result_valid;
    logic                 r_busy;
    logic                 r_err_idx;

    function automatic logic rowOk(input logic [J_WIDTH-1:0] row);
        return row < ROW_LIMIT;
    endfunction

    function automatic logic colOk(input logic [AWIDTH-1:0] col);
        return col < COL_LIMIT;
    endfunction

    // Out-of-range reads return 0; such beats are discarded anyway, this just
    // keeps the array access in bounds.
    function automatic logic signed [LW-1:0] readLlr(input logic [J_WIDTH-1:0] row,
                                                     input logic [AWIDTH-1:0]  col);
        if (rowOk(row) && colOk(col)) begin
            return r_llr[row[RIW-1:0]][col[CIW-1:0]];
        end
        return '0;
    endfunction

    logic w_idle_like;
    logic w_start;
    logic w_cand;
    logic w_pair;
    logic w_last_beat;
    logic w_range_ok;
    logic signed [LW-1:0] w_m1, w_d1, w_m2, w_d2;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start     = i_idx_tvalid && (i_state_in == 2'd1) && (w_idle_like || (r_state == ST_RUN));
    assign w_cand      = i_idx_tvalid && (r_state == ST_RUN) && i_state_in[1];
    assign w_pair      = (i_state_in == 2'd3);
    assign w_last_beat = i_idx_tvalid && i_idx_tlast && ((r_state == ST_RUN) || w_start);

    // The second index pair only matters for pair beats.
    assign w_range_ok = rowOk(i_mult_row1) && colOk(i_mult_col1) &&
                        rowOk(i_divi_row1) && colOk(i_divi_col1) &&
                        (!w_pair || (rowOk(i_mult_row2) && colOk(i_mult_col2) &&
                                     rowOk(i_divi_row2) && colOk(i_divi_col2)));

    assign w_m1 = readLlr(i_mult_row1, i_mult_col1);
    assign w_d1 = readLlr(i_divi_row1, i_divi_col1);
    assign w_m2 = readLlr(i_mult_row2, i_mult_col2);
    assign w_d2 = readLlr(i_divi_row2, i_divi_col2);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. DRAIN leaves once the tlast beat has cleared stage 2,
    // which is exactly when the pipeline is empty since nothing enters in DRAIN.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_next_state = w_last_beat ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_beat) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_s2_last) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Likelihood table; only writable between frames so a frame sees a stable table.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < J; j++) begin
                for (int a = 0; a < A; a++) begin
                    r_llr[j][a] <= '0;
                end
            end
        end else if (i_llr_wr_en && w_idle_like && rowOk(i_llr_wr_row) && colOk(i_llr_wr_col)) begin
            r_llr[i_llr_wr_row[RIW-1:0]][i_llr_wr_col[CIW-1:0]] <= i_llr_wr_data;
        end
    end

    // Stage 1: table reads and beat attributes. Single beats zero the second
    // term pair so stage 2 can always add both differences.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_cand <= 1'b0;
            r_s1_pair <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_m1   <= '0;
            r_s1_d1   <= '0;
            r_s1_m2   <= '0;
            r_s1_d2   <= '0;
            r_s1_row1 <= '0;
            r_s1_row2 <= '0;
            r_s1_col1 <= '0;
            r_s1_col2 <= '0;
        end else begin
            r_s1_cand <= w_cand && w_range_ok;
            r_s1_pair <= w_pair;
            r_s1_last <= w_last_beat;
            r_s1_m1   <= w_m1;
            r_s1_d1   <= w_d1;
            r_s1_m2   <= w_pair ? w_m2 : '0;
            r_s1_d2   <= w_pair ? w_d2 : '0;
            r_s1_row1 <= i_mult_row1;
            r_s1_row2 <= w_pair ? i_mult_row2 : '0;
            r_s1_col1 <= i_mult_col1;
            r_s1_col2 <= w_pair ? i_mult_col2 : '0;
        end
    end

    // Stage 2 arithmetic: the difference sum fits in LW+2 bits, the base add in
    // MW+1 bits, and the result is clamped back into the signed MW range.
    logic [LW:0]          w_diff1, w_diff2;
    logic [LW+1:0]        w_delta;
    logic signed [MW:0]   w_sum_wide;
    logic signed [MW-1:0] w_sum;

    assign w_diff1    = {r_s1_m1[LW-1], r_s1_m1} - {r_s1_d1[LW-1], r_s1_d1};
    assign w_diff2    = {r_s1_m2[LW-1], r_s1_m2} - {r_s1_d2[LW-1], r_s1_d2};
    assign w_delta    = {w_diff1[LW], w_diff1} + {w_diff2[LW], w_diff2};
    assign w_sum_wide = {r_base[MW-1], r_base} + {{(MW-LW-1){w_delta[LW+1]}}, w_delta};

    always_comb begin
        w_sum = w_sum_wide[MW-1:0];
        if (w_sum_wide[MW] != w_sum_wide[MW-1]) begin
            w_sum = w_sum_wide[MW] ? METRIC_MIN : METRIC_MAX;
        end
    end

    // Frame bookkeeping and best tracking. A frame start wins over a beat still
    // in stage 1, which is how an aborted frame's leftover beat is dropped.
    // Strict '>' keeps the earliest of equal candidates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_last      <= 1'b0;
            r_base         <= '0;
            r_best_metric  <= '0;
            r_best_row1    <= '0;
            r_best_row2    <= '0;
            r_best_col1    <= '0;
            r_best_col2    <= '0;
            r_best_is_pair <= 1'b0;
            r_cand_cnt     <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_err_idx      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_start) begin
                r_s2_last      <= 1'b0;
                r_base         <= i_base_metric;
                r_best_metric  <= i_base_metric;
                r_best_row1    <= '0;
                r_best_row2    <= '0;
                r_best_col1    <= '0;
                r_best_col2    <= '0;
                r_best_is_pair <= 1'b0;
                r_cand_cnt     <= '0;
                r_busy         <= 1'b1;
                r_err_idx      <= 1'b0;
            end else begin
                r_s2_last <= r_s1_last;
                if (w_cand && !w_range_ok) begin
                    r_err_idx <= 1'b1;
                end
                if (r_s1_cand) begin
                    if (r_cand_cnt != 16'hFFFF) begin
                        r_cand_cnt <= r_cand_cnt + 16'd1;
                    end
                    if (w_sum > r_best_metric) begin
                        r_best_metric  <= w_sum;
                        r_best_row1    <= r_s1_row1;
                        r_best_row2    <= r_s1_row2;
                        r_best_col1    <= r_s1_col1;
                        r_best_col2    <= r_s1_col2;
                        r_best_is_pair <= r_s1_pair;
                    end
                end
                if ((r_state == ST_DRAIN) && r_s2_last) begin
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                end
            end
        end
    end

    assign o_best_metric  = r_best_metric;
    assign o_best_row1    = r_best_row1;
    assign o_best_row2    = r_best_row2;
    assign o_best_col1    = r_best_col1;
    assign o_best_col2    = r_best_col2;
    assign o_best_is_pair = r_best_is_pair;
    assign o_cand_cnt     = r_cand_cnt;
    assign o_result_valid = r_result_valid;
    assign o_busy         = r_busy;
    assign o_err_idx      = r_err_idx;

endmodule

// File: tb/tb_index_metric_eval.sv
// -----------------------------------------------------------------------------
// tb_index_metric_eval
//
// Self-checking bench for index_metric_eval, built with J=4, A=2 so that row 4
// and column 2 are out of range. Expected frame results are pushed onto a
// scoreboard queue when a frame is driven and popped when result_valid pulses.
// -----------------------------------------------------------------------------
module tb_index_metric_eval;

   localparam int TJ  = 4;
   localparam int TA  = 2;
   localparam int TLW = 12;
   localparam int TMW = 20;
   localparam int JW  = 3;
   localparam int AW  = 2;

   logic clock = 1'b0;
   logic reset;
   logic llrWrEn;
   logic [JW-1:0] llrWrRow;
   logic [AW-1:0] llrWrCol;
   logic signed [TLW-1:0] llrWrData;
   logic signed [TMW-1:0] baseMetric;
   logic idxValid;
   logic idxLast;
   logic [1:0] stateIn;
   logic [AW-1:0] multCol1, multCol2, diviCol1, diviCol2;
   logic [JW-1:0] multRow1, multRow2, diviRow1, diviRow2;
   logic signed [TMW-1:0] bestMetric;
   logic [JW-1:0] bestRow1, bestRow2;
   logic [AW-1:0] bestCol1, bestCol2;
   logic bestIsPair;
   logic [15:0] candCnt;
   logic resultValid;
   logic busy;
   logic errIdx;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      int metric;
      int row1;
      int row2;
      int col1;
      int col2;
      int pair;
      int cnt;
      int err;
   } exp_t;

   typedef struct {
      int kind;
      int mr1, mc1, dr1, dc1;
      int mr2, mc2, dr2, dc2;
      int base;
      exp_t exp;
   } vec_t;

   exp_t sbQ[$];
   exp_t popped;
   vec_t vecs[10];

   index_metric_eval #(.J(TJ), .A(TA), .LW(TLW), .MW(TMW)) dut (
      .i_clk(clock),
      .i_rst(reset),
      .i_llr_wr_en(llrWrEn),
      .i_llr_wr_row(llrWrRow),
      .i_llr_wr_col(llrWrCol),
      .i_llr_wr_data(llrWrData),
      .i_base_metric(baseMetric),
      .i_idx_tvalid(idxValid),
      .i_idx_tlast(idxLast),
      .i_state_in(stateIn),
      .i_mult_col1(multCol1),
      .i_mult_col2(multCol2),
      .i_mult_row1(multRow1),
      .i_mult_row2(multRow2),
      .i_divi_col1(diviCol1),
      .i_divi_col2(diviCol2),
      .i_divi_row1(diviRow1),
      .i_divi_row2(diviRow2),
      .o_best_metric(bestMetric),
      .o_best_row1(bestRow1),
      .o_best_row2(bestRow2),
      .o_best_col1(bestCol1),
      .o_best_col2(bestCol2),
      .o_best_is_pair(bestIsPair),
      .o_cand_cnt(candCnt),
      .o_result_valid(resultValid),
      .o_busy(busy),
      .o_err_idx(errIdx)
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Hard stop in case something wedges the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pushExp(input int metric, input int row1, input int row2, input int col1,
                          input int col2, input int pair, input int cnt, input int err);
      exp_t e;
      e.metric = metric; e.row1 = row1; e.row2 = row2; e.col1 = col1;
      e.col2 = col2; e.pair = pair; e.cnt = cnt; e.err = err;
      sbQ.push_back(e);
   endtask

   // Drives one index beat for exactly one clock edge
   task automatic applyStimulus(input int last, input int kind,
                                input int mr1, input int mc1, input int dr1, input int dc1,
                                input int mr2, input int mc2, input int dr2, input int dc2,
                                input int base);
      idxValid   = 1'b1;
      idxLast    = last[0];
      stateIn    = kind[1:0];
      multRow1   = mr1[JW-1:0];
      multCol1   = mc1[AW-1:0];
      diviRow1   = dr1[JW-1:0];
      diviCol1   = dc1[AW-1:0];
      multRow2   = mr2[JW-1:0];
      multCol2   = mc2[AW-1:0];
      diviRow2   = dr2[JW-1:0];
      diviCol2   = dc2[AW-1:0];
      baseMetric = base[TMW-1:0];
      tick();
      idxValid = 1'b0;
      idxLast  = 1'b0;
      stateIn  = 2'd0;
   endtask

   task automatic startFrame(input int base, input int last);
      applyStimulus(last, 1, 0, 0, 0, 0, 0, 0, 0, 0, base);
   endtask

   task automatic single(input int mr, input int mc, input int dr, input int dc, input int last);
      applyStimulus(last, 2, mr, mc, dr, dc, 0, 0, 0, 0, 0);
   endtask

   task automatic pairBeat(input int mr1, input int mc1, input int dr1, input int dc1,
                           input int mr2, input int mc2, input int dr2, input int dc2, input int last);
      applyStimulus(last, 3, mr1, mc1, dr1, dc1, mr2, mc2, dr2, dc2, 0);
   endtask

   task automatic writeLlr(input int row, input int col, input int data);
      llrWrEn   = 1'b1;
      llrWrRow  = row[JW-1:0];
      llrWrCol  = col[AW-1:0];
      llrWrData = data[TLW-1:0];
      tick();
      llrWrEn = 1'b0;
   endtask

   task automatic loadStdTable();
      for (int j = 0; j < TJ; j++) begin
         writeLlr(j, 0, 0);
         writeLlr(j, 1, 10 * (j + 1));
      end
   endtask

   // Waits (bounded) until every pushed expectation has been consumed
   task automatic waitDrain();
      for (int i = 0; i < 20; i++) begin
         if (sbQ.size() == 0) break;
         @(negedge clock);
      end
      checkOutput("drainTimeout", sbQ.size(), 0);
      tick();
   endtask

   // Scoreboard consumer: compare every reported result with the next expectation
   always @(negedge clock) begin
      if (!reset && resultValid) begin
         checkOutput("resultExpected", (sbQ.size() > 0) ? 1 : 0, 1);
         if (sbQ.size() > 0) begin
            popped = sbQ.pop_front();
            checkOutput("bestMetric", int'(bestMetric), popped.metric);
            checkOutput("bestRow1", int'(bestRow1), popped.row1);
            checkOutput("bestRow2", int'(bestRow2), popped.row2);
            checkOutput("bestCol1", int'(bestCol1), popped.col1);
            checkOutput("bestCol2", int'(bestCol2), popped.col2);
            checkOutput("bestIsPair", int'(bestIsPair), popped.pair);
            checkOutput("candCnt", int'(candCnt), popped.cnt);
            checkOutput("errIdx", int'(errIdx), popped.err);
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_metric"}, int'(bestMetric), 0);
      checkOutput({tag, "_rows"}, int'(bestRow1) + int'(bestRow2), 0);
      checkOutput({tag, "_cols"}, int'(bestCol1) + int'(bestCol2), 0);
      checkOutput({tag, "_pair"}, int'(bestIsPair), 0);
      checkOutput({tag, "_cnt"}, int'(candCnt), 0);
      checkOutput({tag, "_valid"}, int'(resultValid), 0);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_err"}, int'(errIdx), 0);
   endtask

   initial begin
      int rvCount;

      // Vector table on the standard table L[j][0]=0, L[j][1]=10*(j+1)
      //           kind mr1 mc1 dr1 dc1 mr2 mc2 dr2 dc2 base    metric r1 r2 c1 c2 pair cnt err
      vecs[0] = '{2, 2, 1, 2, 0, 0, 0, 0, 0, 100, '{130, 2, 0, 1, 0, 0, 1, 0}};
      vecs[1] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 100, '{100, 0, 0, 0, 0, 0, 1, 0}};
      vecs[2] = '{3, 1, 1, 1, 0, 3, 1, 3, 0, 100, '{160, 1, 3, 1, 1, 1, 1, 0}};
      vecs[3] = '{3, 1, 0, 1, 1, 3, 1, 3, 0, 100, '{120, 1, 3, 0, 1, 1, 1, 0}};
      vecs[4] = '{2, 4, 1, 4, 0, 0, 0, 0, 0, 100, '{100, 0, 0, 0, 0, 0, 0, 1}};
      vecs[5] = '{2, 1, 2, 1, 0, 0, 0, 0, 0, 100, '{100, 0, 0, 0, 0, 0, 0, 1}};
      vecs[6] = '{2, 3, 1, 3, 0, 0, 0, 0, 0, -50, '{-10, 3, 0, 1, 0, 0, 1, 0}};
      vecs[7] = '{2, 0, 1, 1, 1, 0, 0, 0, 0,   0, '{0,   0, 0, 0, 0, 0, 1, 0}};
      vecs[8] = '{3, 1, 1, 1, 0, 5, 1, 5, 0, 100, '{100, 0, 0, 0, 0, 0, 0, 1}};
      vecs[9] = '{2, 2, 1, 2, 0, 7, 3, 7, 3, 100, '{130, 2, 0, 1, 0, 0, 1, 0}};

      reset = 1'b1; llrWrEn = 1'b0; llrWrRow = '0; llrWrCol = '0; llrWrData = '0;
      baseMetric = '0; idxValid = 1'b0; idxLast = 1'b0; stateIn = 2'd0;
      multRow1 = '0; multCol1 = '0; diviRow1 = '0; diviCol1 = '0;
      multRow2 = '0; multCol2 = '0; diviRow2 = '0; diviCol2 = '0;
      repeat (3) tick();
      checkAllZero("reset");
      reset = 1'b0;
      tick();

      // Out-of-range write must not alias onto row 1
      writeLlr(5, 1, 999);
      loadStdTable();

      $display("[TB] basic frame with latency check");
      pushExp(130, 2, 0, 1, 0, 0, 1, 0);
      startFrame(100, 0);
      checkOutput("busyAfterStart", int'(busy), 1);
      single(2, 1, 2, 0, 1);
      checkOutput("rvAfterS1", int'(resultValid), 0);
      tick();
      checkOutput("rvAfterS2", int'(resultValid), 0);
      checkOutput("busyInDrain", int'(busy), 1);
      tick();
      checkOutput("rvDoneEntry", int'(resultValid), 1);
      checkOutput("busyAtResult", int'(busy), 0);
      tick();
      checkOutput("rvPulseEnd", int'(resultValid), 0);
      checkOutput("bestHeldInDone", int'(bestMetric), 130);
      waitDrain();

      $display("[TB] vector table");
      for (int i = 0; i < 10; i++) begin
         sbQ.push_back(vecs[i].exp);
         startFrame(vecs[i].base, 0);
         applyStimulus(1, vecs[i].kind, vecs[i].mr1, vecs[i].mc1, vecs[i].dr1, vecs[i].dc1,
                       vecs[i].mr2, vecs[i].mc2, vecs[i].dr2, vecs[i].dc2, 0);
         waitDrain();
      end

      $display("[TB] multi-beat frame with ignored beat");
      pushExp(160, 1, 3, 1, 1, 1, 5, 0);
      startFrame(100, 0);
      for (int j = 0; j < TJ; j++) begin
         single(j, 1, j, 0, 0);
      end
      applyStimulus(0, 0, 7, 3, 7, 3, 7, 3, 7, 3, 0);
      pairBeat(1, 1, 1, 0, 3, 1, 3, 0, 1);
      waitDrain();

      $display("[TB] tie keeps first, negative never replaces");
      pushExp(120, 1, 0, 1, 0, 0, 3, 0);
      startFrame(100, 0);
      single(1, 1, 1, 0, 0);
      single(3, 1, 1, 1, 0);
      single(2, 0, 2, 1, 1);
      waitDrain();

      $display("[TB] empty frame");
      pushExp(250, 0, 0, 0, 0, 0, 0, 0);
      startFrame(250, 1);
      rvCount = 0;
      for (int i = 0; i < 6; i++) begin
         if (resultValid) rvCount++;
         tick();
      end
      checkOutput("emptyPulseCount", rvCount, 1);
      waitDrain();

      $display("[TB] restart aborts in-flight candidate");
      pushExp(120, 1, 0, 1, 0, 0, 1, 0);
      startFrame(100, 0);
      single(3, 1, 3, 0, 0);
      startFrame(100, 0);
      single(1, 1, 1, 0, 1);
      waitDrain();

      $display("[TB] write together with frame start");
      pushExp(170, 3, 0, 1, 0, 0, 1, 0);
      llrWrEn = 1'b1; llrWrRow = 3'd3; llrWrCol = 2'd1; llrWrData = 12'sd70;
      startFrame(100, 0);
      llrWrEn = 1'b0;
      single(3, 1, 3, 0, 1);
      waitDrain();
      writeLlr(3, 1, 40);

      $display("[TB] write during RUN is dropped");
      pushExp(110, 0, 0, 1, 0, 0, 1, 0);
      startFrame(100, 0);
      writeLlr(2, 1, 500);
      single(0, 1, 0, 0, 1);
      waitDrain();
      pushExp(130, 2, 0, 1, 0, 0, 1, 0);
      startFrame(100, 0);
      single(2, 1, 2, 0, 1);
      waitDrain();

      $display("[TB] positive saturation");
      writeLlr(0, 1, 2047);
      writeLlr(1, 1, 2047);
      pushExp(524287, 0, 1, 1, 1, 1, 1, 0);
      startFrame(524188, 0);
      pairBeat(0, 1, 0, 0, 1, 1, 1, 0, 1);
      waitDrain();

      $display("[TB] reset mid-frame");
      startFrame(100, 0);
      single(2, 1, 2, 0, 0);
      reset = 1'b1;
      tick();
      checkAllZero("midReset");
      reset = 1'b0;
      repeat (6) tick();
      // Table was cleared by reset, so this candidate only ties the base
      pushExp(100, 0, 0, 0, 0, 0, 1, 0);
      startFrame(100, 0);
      single(2, 1, 2, 0, 1);
      waitDrain();

      checkOutput("scoreboardEmpty", sbQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
